// File: rtl/uart_mem_loader.sv
// Boot loader: receives a framed program image over UART and writes it word by word into
// the 128x32 memory, holding the CPU in reset until the image checksum verifies.
module uart_mem_loader #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         WR_CYCLES    = 2,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx,
  output logic       CS,
  output logic       WE,
  output logic [6:0] ADDR,
  inout  wire [31:0] Mem_Bus,
  output logic       loading,
  output logic       cpu_rst,
  output logic       err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int WW = $clog2(WR_CYCLES + 1);
  localparam logic [WW-1:0] WR_LAST = WW'(WR_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_IDLE, ST_COUNT, ST_DATA, ST_WRITE, ST_CHECK, ST_DONE, ST_ERR} st_t;

  rx_state_t       r_rx_state;
  logic            r_rx_s1, r_rx_s2, r_rx_d;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_sh, r_rx_byte;
  logic            r_rx_done, r_rx_ok;

  st_t             r_state;
  logic [7:0]      r_n, r_idx, r_chk;
  logic [1:0]      r_bcnt;
  logic [31:0]     r_word;
  logic [WW-1:0]   r_wcnt;
  logic            r_cs, r_we, r_loading, r_cpu_rst, r_err;
  logic [6:0]      r_addr;
  logic            r_hold_vld, r_hold_ok;
  logic [7:0]      r_hold_byte;

  logic            w_busy, w_in_vld, w_in_ok, w_take, w_byte_vld, w_ferr;
  logic [7:0]      w_in_byte;

  // Receiver: runs free of the FSM; start bit is re-qualified at mid-bit to reject glitches
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_byte  <= '0;
      r_rx_done  <= 1'b0;
      r_rx_ok    <= 1'b0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_d    <= r_rx_s2;
      r_rx_done <= 1'b0;
      r_rx_cnt  <= r_rx_cnt + 1'b1;
      case (r_rx_state)
        RX_IDLE: if (r_rx_d && !r_rx_s2) begin
          r_rx_state <= RX_START;
          r_rx_cnt   <= '0;
        end
        RX_START: if (r_rx_cnt == CNT_HALF) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (r_rx_cnt == CNT_LAST) begin
          r_rx_cnt <= '0;
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 1'b1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
        end
        RX_STOP: if (r_rx_cnt == CNT_LAST) begin
          r_rx_done  <= 1'b1;
          r_rx_ok    <= r_rx_s2;
          r_rx_byte  <= r_rx_sh;
          r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // A byte landing during WRITE waits in the holding register until the write finishes
  assign w_busy     = (r_state == ST_WRITE);
  assign w_in_vld   = r_rx_done | r_hold_vld;
  assign w_in_ok    = r_hold_vld ? r_hold_ok : r_rx_ok;
  assign w_in_byte  = r_hold_vld ? r_hold_byte : r_rx_byte;
  assign w_take     = w_in_vld & ~w_busy;
  assign w_byte_vld = w_take & w_in_ok;
  assign w_ferr     = w_take & ~w_in_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_idx       <= '0;
      r_chk       <= '0;
      r_bcnt      <= '0;
      r_word      <= '0;
      r_wcnt      <= '0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_loading   <= 1'b1;
      r_cpu_rst   <= 1'b1;
      r_err       <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_ok   <= 1'b0;
      r_hold_byte <= '0;
    end else begin
      if (w_busy && r_rx_done) begin
        r_hold_vld  <= 1'b1;
        r_hold_ok   <= r_rx_ok;
        r_hold_byte <= r_rx_byte;
      end else if (w_take) begin
        r_hold_vld <= 1'b0;
      end
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: if (w_byte_vld && w_in_byte == SYNC_BYTE) begin
          r_state   <= ST_COUNT;
          r_chk     <= '0;
          r_err     <= 1'b0;
          r_loading <= 1'b1;
          r_cpu_rst <= 1'b1;
        end
        ST_COUNT: if (w_byte_vld) begin
          if (w_in_byte > 8'd128) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end else if (w_in_byte == 8'd0) begin
            r_state <= ST_CHECK;
          end else begin
            r_n     <= w_in_byte;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: if (w_byte_vld) begin
          r_word <= {r_word[23:0], w_in_byte};
          r_chk  <= r_chk ^ w_in_byte;
          r_bcnt <= r_bcnt + 1'b1;
          if (r_bcnt == 2'd3) begin
            r_state <= ST_WRITE;
            r_wcnt  <= '0;
            r_cs    <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= r_idx[6:0];
          end
        end
        ST_WRITE: begin
          r_wcnt <= r_wcnt + 1'b1;
          if (r_wcnt == WR_LAST) begin
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_idx   <= r_idx + 8'd1;
            r_state <= (r_idx + 8'd1 == r_n) ? ST_CHECK : ST_DATA;
          end
        end
        ST_CHECK: if (w_byte_vld) begin
          if (w_in_byte == r_chk) begin
            r_state   <= ST_DONE;
            r_loading <= 1'b0;
            r_cpu_rst <= 1'b0;
          end else begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Framing error overrides whatever the byte-level FSM decided
      if (w_ferr) begin
        r_state   <= ST_ERR;
        r_err     <= 1'b1;
        r_loading <= 1'b1;
        r_cpu_rst <= 1'b1;
      end
    end
  end

  assign CS      = r_cs;
  assign WE      = r_we;
  assign ADDR    = r_addr;
  assign loading = r_loading;
  assign cpu_rst = r_cpu_rst;
  assign err     = r_err;
  assign Mem_Bus = r_we ? r_word : 32'bz;
endmodule
